// File: rtl/bch_encode_par.sv
// Systematic parallel BCH encoder: BITS bits per enabled cycle, K data beats then N-K parity bits.
// The generator polynomial is derived at elaboration from the cyclotomic cosets of alpha^1..alpha^2T.
module bch_encode_par #(
    parameter int N    = 15,
    parameter int K    = 5,
    parameter int T    = 3,
    parameter int BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            start,
    input  logic [BITS-1:0] din,
    output logic            vdin,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    output logic            first,
    output logic            last
);
    function automatic int n2m(input int n);
        int m;
        m = 1;
        while (((1 << m) - 1) < n) m++;
        return m;
    endfunction

    function automatic int prim_poly(input int m);
        case (m)
            2:       return 'h7;
            3:       return 'hB;
            4:       return 'h13;
            5:       return 'h25;
            6:       return 'h43;
            7:       return 'h89;
            8:       return 'h11D;
            default: return 0;
        endcase
    endfunction

    localparam int M    = n2m(N);
    localparam int PRIM = prim_poly(M);
    localparam int P    = N - K;
    localparam int KB   = K / BITS;
    localparam int PB   = P / BITS;
    localparam int CW   = $clog2(KB + PB);
    localparam int MAXQ = 256;

    function automatic int gf_mul(input int a, input int b);
        int r;
        r = 0;
        for (int i = M - 1; i >= 0; i--) begin
            r = r << 1;
            if (((r >> M) & 1) != 0) r = r ^ PRIM;
            if (((b >> i) & 1) != 0) r = r ^ a;
        end
        return r;
    endfunction

    // Union of the conjugacy classes of alpha^1..alpha^2T: the roots of g(x).
    function automatic logic [MAXQ-1:0] root_set();
        logic [MAXQ-1:0] roots;
        int q;
        int j;
        roots = '0;
        q = (1 << M) - 1;
        for (int i = 1; i <= 2 * T; i++) begin
            j = i % q;
            for (int s = 0; s < M; s++) begin
                if (j < MAXQ) roots[j] = 1'b1;
                j = (2 * j) % q;
            end
        end
        return roots;
    endfunction

    function automatic logic [P-1:0] gen_poly(input logic [MAXQ-1:0] roots);
        logic [8*MAXQ-1:0] c;
        logic [P-1:0]      g;
        int a;
        int deg;
        int lo;
        int hi;
        c      = '0;
        c[7:0] = 8'd1;
        deg    = 0;
        a      = 1;
        for (int r = 0; r < MAXQ - 1; r++) begin
            if (roots[r] && deg < MAXQ - 1) begin
                for (int k = deg + 1; k >= 0; k--) begin
                    if (k > 0) lo = int'(c[8*(k-1) +: 8]);
                    else       lo = 0;
                    hi = int'(c[8*k +: 8]);
                    c[8*k +: 8] = 8'(lo ^ gf_mul(hi, a));
                end
                deg++;
            end
            a = gf_mul(a, 2);
        end
        for (int k = 0; k < P; k++) g[k] = c[8*k];
        return g;
    endfunction

    localparam logic [MAXQ-1:0] ROOTS = root_set();
    localparam logic [P-1:0]    GPOLY = gen_poly(ROOTS);

    generate
        if ((K % BITS) != 0 || (P % BITS) != 0) begin : g_bits_bad
            $error("bch_encode_par: BITS must divide both K and N-K");
        end
        if (M > 8 || PRIM == 0) begin : g_m_bad
            $error("bch_encode_par: unsupported field size");
        end
        if ($countones(ROOTS) != P) begin : g_deg_bad
            $error("bch_encode_par: degree of g(x) does not equal N-K");
        end
    endgenerate

    localparam logic [1:0]    IDLE    = 2'd0;
    localparam logic [1:0]    DATA    = 2'd1;
    localparam logic [1:0]    PARITY  = 2'd2;
    localparam logic [CW-1:0] KB_LAST = CW'(KB - 1);
    localparam logic [CW-1:0] PB_LAST = CW'(PB - 1);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [P-1:0]  lfsr;
    logic [P-1:0]  lfsr_data;
    logic [P-1:0]  lfsr_par;
    logic          fb;

    assign vdin = (state == DATA) & reset;

    // BITS serial division steps unrolled, earliest bit (BITS-1) first.
    always_comb begin
        fb        = 1'b0;
        lfsr_data = lfsr;
        for (int i = BITS - 1; i >= 0; i--) begin
            fb        = lfsr_data[P-1] ^ din[i];
            lfsr_data = (lfsr_data << 1) ^ ({P{fb}} & GPOLY);
        end
    end

    assign lfsr_par = lfsr << BITS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            lfsr       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            first      <= 1'b0;
            last       <= 1'b0;
        end else if (ce) begin
            case (state)
                DATA: begin
                    lfsr       <= lfsr_data;
                    dout       <= din;
                    dout_valid <= 1'b1;
                    first      <= (count == '0);
                    last       <= 1'b0;
                    if (count == KB_LAST) begin
                        state <= PARITY;
                        count <= '0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                PARITY: begin
                    dout       <= lfsr[P-1 -: BITS];
                    dout_valid <= 1'b1;
                    first      <= 1'b0;
                    last       <= (count == PB_LAST);
                    if (count == PB_LAST) begin
                        count <= '0;
                        if (start) begin
                            state <= DATA;
                            lfsr  <= '0;
                        end else begin
                            state <= IDLE;
                            lfsr  <= lfsr_par;
                        end
                    end else begin
                        count <= count + CW'(1);
                        lfsr  <= lfsr_par;
                    end
                end
                default: begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                    first      <= 1'b0;
                    last       <= 1'b0;
                    if (state == IDLE && start) begin
                        state <= DATA;
                        count <= '0;
                        lfsr  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bch_encode_par.sv
// Bench for bch_encode_par: BITS=1 and BITS=5 instances of the (15,5,3) code, checked against
// constant vectors and a polynomial long-division reference.
module tb_bch_encode_par;
    localparam logic [10:0] G = 11'b10100110111;

    typedef struct packed {
        logic       dv;
        logic [4:0] d;
        logic       f;
        logic       l;
    } samp_t;

    typedef struct {
        logic [4:0]  data;
        logic [14:0] cw;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       ce1, start1, vdin1, dv1, first1, last1;
    logic [0:0] din1, dout1;
    logic       ce5, start5, vdin5, dv5, first5, last5;
    logic [4:0] din5, dout5;

    int    checks = 0;
    int    errors = 0;
    samp_t s1[$];
    samp_t s5[$];
    logic  ce_q1, ce_q5;
    bit    chk_hold = 0;
    int    hold_bad = 0;
    int    vd1_cnt = 0, vd5_cnt = 0;
    logic [3:0] prev1;
    logic [7:0] prev5;

    vec_t        tbl[3];
    logic [29:0] st, fv, lv;
    int          nv, gp, v0;
    logic [4:0]  w;

    bch_encode_par #(.N(15), .K(5), .T(3), .BITS(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce1), .start(start1), .din(din1), .vdin(vdin1),
        .dout(dout1), .dout_valid(dv1), .first(first1), .last(last1));

    bch_encode_par #(.N(15), .K(5), .T(3), .BITS(5)) u5 (
        .clk(clk), .reset(reset), .ce(ce5), .start(start5), .din(din5), .vdin(vdin5),
        .dout(dout5), .dout_valid(dv5), .first(first5), .last(last5));

    always @(posedge clk) begin
        ce_q1 <= ce1;
        ce_q5 <= ce5;
    end

    // Record every enabled cycle's outputs; while stalled the outputs must not move.
    always @(negedge clk) begin
        if (ce_q1 === 1'b1) s1.push_back('{dv1, {4'b0, dout1}, first1, last1});
        else if (chk_hold && ({dv1, dout1, first1, last1} !== prev1)) hold_bad++;
        if (ce_q5 === 1'b1) s5.push_back('{dv5, dout5, first5, last5});
        else if (chk_hold && ({dv5, dout5, first5, last5} !== prev5)) hold_bad++;
        prev1 = {dv1, dout1, first1, last1};
        prev5 = {dv5, dout5, first5, last5};
        if (vdin1) vd1_cnt++;
        if (vdin5) vd5_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Codeword = data followed by remainder of data(x)*x^10 divided by g(x).
    function automatic logic [14:0] ref_cw(input logic [4:0] d);
        logic [14:0] r;
        r = {d, 10'b0};
        for (int i = 14; i >= 10; i--)
            if (r[i]) r = r ^ (15'(G) << (i - 10));
        return {d, r[9:0]};
    endfunction

    function automatic int count_valid(input samp_t q[$]);
        int n;
        n = 0;
        foreach (q[i]) if (q[i].dv) n++;
        return n;
    endfunction

    task automatic analyze(input samp_t q[$], input int bpb, output logic [29:0] stream,
                           output logic [29:0] fvec, output logic [29:0] lvec,
                           output int nvalid, output int gaps);
        int fi;
        int li;
        fi = -1;
        li = -1;
        stream = '0;
        fvec = '0;
        lvec = '0;
        nvalid = 0;
        foreach (q[i]) begin
            if (q[i].dv) begin
                if (fi < 0) fi = i;
                li = i;
                stream = (stream << bpb) | 30'(q[i].d);
                fvec = {fvec[28:0], q[i].f};
                lvec = {lvec[28:0], q[i].l};
                nvalid++;
            end
        end
        gaps = (fi < 0) ? 0 : (li - fi + 1 - nvalid);
    endtask

    task automatic send1(input logic [4:0] w0, input logic [4:0] w1, input int nw, input int pct);
        int wi, bi, guard;
        logic [4:0] cur;
        wi = 0; bi = 0; guard = 0;
        s1.delete();
        while (wi < nw && guard < 1000) begin
            @(negedge clk);
            guard++;
            cur = (wi == 0) ? w0 : w1;
            start1 = !(vdin1 && wi == nw - 1);
            ce1 = ($urandom_range(99) >= pct);
            din1 = cur[4 - bi];
            if (ce1 && vdin1) begin
                bi++;
                if (bi == 5) begin bi = 0; wi++; end
            end
        end
        start1 = 1'b0;
        while (count_valid(s1) < 15 * nw && guard < 1000) begin
            @(negedge clk);
            guard++;
            ce1 = ($urandom_range(99) >= pct);
        end
        ce1 = 1'b1;
        repeat (2) @(negedge clk);
        check("timeout1", (guard < 1000), 1);
    endtask

    task automatic send5(input logic [4:0] w0, input logic [4:0] w1, input int nw, input int pct);
        int wi, guard;
        wi = 0; guard = 0;
        s5.delete();
        while (wi < nw && guard < 1000) begin
            @(negedge clk);
            guard++;
            start5 = !(vdin5 && wi == nw - 1);
            ce5 = ($urandom_range(99) >= pct);
            din5 = (wi == 0) ? w0 : w1;
            if (ce5 && vdin5) wi++;
        end
        start5 = 1'b0;
        while (count_valid(s5) < 3 * nw && guard < 1000) begin
            @(negedge clk);
            guard++;
            ce5 = ($urandom_range(99) >= pct);
        end
        ce5 = 1'b1;
        repeat (2) @(negedge clk);
        check("timeout5", (guard < 1000), 1);
    endtask

    initial begin
        reset = 1'b1;
        ce1 = 0; start1 = 0; din1 = 0;
        ce5 = 0; start5 = 0; din5 = 0;
        #2 reset = 1'b0;
        #11;
        check("rst_out1", {dv1, dout1, first1, last1, vdin1}, 0);
        check("rst_out5", {dv5, dout5, first5, last5, vdin5}, 0);
        #4 reset = 1'b1;

        tbl[0] = '{5'b10000, 15'h429B};
        tbl[1] = '{5'b11111, 15'h7FFF};
        tbl[2] = '{5'b00000, 15'h0000};
        foreach (tbl[i]) begin
            v0 = vd1_cnt;
            send1(tbl[i].data, 5'b0, 1, 0);
            analyze(s1, 1, st, fv, lv, nv, gp);
            check("tbl_cw1", st[14:0], tbl[i].cw);
            check("tbl_first1", fv[14:0], 15'h4000);
            check("tbl_last1", lv[14:0], 15'h0001);
            check("tbl_span1", nv, 15);
            check("tbl_gaps1", gp, 0);
            check("tbl_vdin1", vd1_cnt - v0, 5);
            v0 = vd5_cnt;
            send5(tbl[i].data, 5'b0, 1, 0);
            analyze(s5, 5, st, fv, lv, nv, gp);
            check("tbl_cw5", st[14:0], tbl[i].cw);
            check("tbl_first5", fv[2:0], 3'b100);
            check("tbl_last5", lv[2:0], 3'b001);
            check("tbl_span5", nv, 3);
            check("tbl_vdin5", vd5_cnt - v0, 1);
        end

        // Back-to-back codewords: start held so it lands on the final parity beat.
        send1(5'b10000, 5'b11111, 2, 0);
        analyze(s1, 1, st, fv, lv, nv, gp);
        check("b2b_cw1", st, {15'h429B, 15'h7FFF});
        check("b2b_first1", fv, 30'h2000_4000);
        check("b2b_last1", lv, 30'h0000_8001);
        check("b2b_span1", nv, 30);
        check("b2b_gaps1", gp, 0);
        send5(5'b10000, 5'b11111, 2, 0);
        analyze(s5, 5, st, fv, lv, nv, gp);
        check("b2b_cw5", st, {15'h429B, 15'h7FFF});
        check("b2b_first5", fv[5:0], 6'b100100);
        check("b2b_gaps5", gp, 0);

        // vdin ignores ce while in DATA.
        @(negedge clk); start5 = 1; ce5 = 1; din5 = 5'b10000;
        @(negedge clk); start5 = 0; ce5 = 0;
        @(negedge clk);
        check("vdin_no_ce", vdin5, 1);
        check("stall_no_out", dv5, 0);
        ce5 = 1;
        repeat (6) @(negedge clk);

        // Random stalls must not alter the codewords.
        chk_hold = 1;
        for (int i = 0; i < 12; i++) begin
            w = 5'($urandom_range(31));
            send1(w, 5'b0, 1, 30);
            analyze(s1, 1, st, fv, lv, nv, gp);
            check("stall_cw1", st[14:0], ref_cw(w));
            check("stall_fl1", {fv[14:0], lv[14:0]}, {15'h4000, 15'h0001});
            send5(w, ~w, 2, 30);
            analyze(s5, 5, st, fv, lv, nv, gp);
            check("stall_cw5", st, {ref_cw(w), ref_cw(~w)});
        end
        send1(5'b10000, 5'b11111, 2, 30);
        analyze(s1, 1, st, fv, lv, nv, gp);
        check("stall_b2b1", st, {15'h429B, 15'h7FFF});
        chk_hold = 0;
        check("hold_violations", hold_bad, 0);

        for (int i = 0; i < 100; i++) begin
            w = 5'($urandom_range(31));
            send1(w, 5'b0, 1, 0);
            analyze(s1, 1, st, fv, lv, nv, gp);
            check("rand_cw1", st[14:0], ref_cw(w));
            send5(w, 5'b0, 1, 0);
            analyze(s5, 5, st, fv, lv, nv, gp);
            check("rand_cw5", st[14:0], ref_cw(w));
        end

        // Asynchronous reset in the middle of the parity phase.
        @(negedge clk); start1 = 1; ce1 = 1; din1 = 0;
        @(negedge clk); start1 = 0; din1 = 1;
        repeat (4) begin @(negedge clk); din1 = 0; end
        repeat (5) @(negedge clk);
        check("mid_parity_valid", dv1, 1);
        #2 reset = 1'b0;
        #1 check("abort_out", {dv1, dout1, first1, last1, vdin1}, 0);
        #3 reset = 1'b1;
        send1(5'b10000, 5'b0, 1, 0);
        analyze(s1, 1, st, fv, lv, nv, gp);
        check("post_rst_cw", st[14:0], 15'h429B);
        check("post_rst_first", fv[14:0], 15'h4000);
        check("post_rst_span", nv, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bch_encode_par.md
Name: bch_encode_par

Overview:
- Systematic BCH encoder that processes BITS bits per clock. It generalises the bit-serial encoder to a parallel datapath with explicit framing and a clock-enable stall.
- Sits between the data source and the channel/modulator in the same BCH codec family.
- Emits K data bits unchanged, followed by N-K parity bits, all MSB-first.
- g(x) is computed at elaboration with the shared bch.vh helpers; M = n2m(N).

Parameters:
- N, 15, codeword length (data + parity); N <= 2^M-1.
- K, 5, data bits per codeword.
- T, 3, correctable errors; selects g(x) of degree N-K.
- BITS, 1, bits per cycle; must divide both K and N-K (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  begin a codeword; sampled when ce=1.
- din  in  BITS  data in; bit BITS-1 is earliest in time.
- vdin  out  1  data is being accepted this cycle.
- dout  out  BITS  encoded output; bit BITS-1 is earliest.
- dout_valid  out  1  dout carries codeword bits.
- first  out  1  dout holds the first beat of a codeword.
- last  out  1  dout holds the final parity beat.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, LFSR=0, count=0. dout, dout_valid, first, last all 0. vdin=0.
- Beat counts: KB=K/BITS data beats, PB=(N-K)/BITS parity beats. count is binary, width clog2(KB+PB).
- FSM states:
  - IDLE: start&ce -> DATA, count=0, LFSR=0.
  - DATA: vdin=1. Each ce cycle consumes din and count++. When count==KB-1 -> PARITY, count=0.
  - PARITY: each ce cycle shifts out BITS parity bits. At count==PB-1: start&ce -> DATA (back-to-back, LFSR cleared); otherwise -> IDLE.
- start in any other state or cycle is ignored.
- vdin is combinational: (state==DATA) & reset high. It does not depend on ce; consumers must qualify it with ce.
- LFSR update per accepted beat: BITS serial steps unrolled in a single cycle, bit BITS-1 first.
  - Serial step: fb = lfsr[N-K-1]^d; lfsr = {lfsr[N-K-2:0],0} ^ ({N-K{fb}} & g[N-K-1:0]).
- PARITY beat: dout = lfsr[N-K-1 -: BITS]; the LFSR shifts left by BITS, zero-filled, with no feedback.
- Output registers (update only when ce=1):
  - DATA beat: dout <= din.
  - PARITY beat: dout <= parity slice.
  - IDLE: dout <= 0.
  - dout_valid <= (DATA|PARITY).
  - first <= (DATA & count==0).
  - last <= (PARITY & count==PB-1).
- Latency: each beat appears on dout exactly 1 enabled cycle after it is consumed. Codeword span is KB+PB consecutive enabled cycles.
- ce=0 mid-codeword: FSM, count, LFSR and output registers freeze. Resuming continues with identical results, with no gaps counted.
- Back-to-back codewords produce no idle beat; first of the next codeword follows last of the previous one directly.
- Reset asserted mid-codeword aborts it. No partial parity is emitted, and outputs go to 0 immediately.

Test Plan:
- N=15,K=5,T=3,BITS=1, g=10100110111b. Data 10000 -> dout stream 100001010011011 (0x429B). first on beat 0, last on beat 14, dout_valid for 15 cycles.
- Same config, data 11111 -> dout stream of 15 ones. Data 00000 -> 15 zeros.
- BITS=5, data 5'b10000 -> dout beats 10000, 10100, 11011. vdin high for 1 cycle, last on the 3rd beat. Results must match BITS=1 for 100 random data words.
- Back-to-back: start held so it is sampled on the last parity beat. Words 10000 then 11111 -> 30 contiguous valid beats, with first asserted at beats 0 and 15.
- Random ce=0 gaps (30% density) during DATA and PARITY -> same codewords as the no-stall run; outputs constant while ce=0.
- reset pulsed low mid-PARITY (asynchronous, not aligned to clk) -> all outputs 0 within the same cycle. A following start produces a correct 0x429B codeword for data 10000.
